a2d_arbiter: RTL

//  Shares the single SPI A2D converter (A2D_intf) between NUM_REQ requesters
//  (slider scanner, volume, mic-level monitor, ...). Round-robin arbitration:

---
 rtl/a2d_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/a2d_arbiter.sv
// rtl/a2d_arbiter.sv - round-robin arbiter sharing one SPI A2D converter between NUM_REQ requesters
module a2d_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_chnnl,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [11:0]            res_out,
    output logic                   err,
    output logic                   strt_cnv,
    output logic [2:0]             chnnl,
    input  logic                   cnv_cmplt,
    input  logic [11:0]            res
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    win_reg;
    logic [IDX_W-1:0]    win_idx;
    logic                win_valid;
    logic [CNT_W-1:0]    cnt;

    // Scan from the highest offset down so the first set request at/after rr_ptr wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            strt_cnv <= 1'b0;
            chnnl    <= 3'd0;
            res_out  <= 12'd0;
            rr_ptr   <= '0;
            win_reg  <= '0;
            cnt      <= '0;
        end else begin
            strt_cnv <= 1'b0;
            done     <= '0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt      <= NUM_REQ'(1) << win_idx;
                        win_reg  <= win_idx;
                        chnnl    <= req_chnnl[3*win_idx +: 3];
                        strt_cnv <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Completion takes precedence over a timeout landing on the same cycle.
                    if (cnv_cmplt) begin
                        res_out <= res;
                        done    <= gnt;
                        state   <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else if (cnt != CNT_W'(TIMEOUT_CYC)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    gnt    <= '0;
                    rr_ptr <= (win_reg == IDX_W'(NUM_REQ - 1)) ? '0 : win_reg + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
